// File: rtl/axi4_sim_ram.sv
// AXI4 slave RAM: FIXED/INCR/WRAP bursts, first R beat READ_LATENCY+1 cycles after AR, B WRITE_LATENCY+1 after last W; one transaction per direction.
// Define AXI4_SIM_RAM_DECERR_EN to return DECERR on out-of-range words instead of aliasing them modulo MEM_WORDS.
module axi4_sim_ram #(
  parameter int DATA_WIDTH    = 128,
  parameter int ADDR_WIDTH    = 32,
  parameter int ID_WIDTH      = 4,
  parameter int MEM_WORDS     = 4096,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LG     = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_WORDS);
`ifdef AXI4_SIM_RAM_DECERR_EN
  localparam bit DECERR_EN = 1'b1;
`else
  localparam bit DECERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  function automatic logic bad_req(input logic [2:0] size, input logic [1:0] burst);
    return (size > 3'(LG)) || (burst == 2'b11);
  endfunction

  function automatic logic oor(input logic [ADDR_WIDTH-1:0] a);
    return DECERR_EN && ((a >> LG) >= ADDR_WIDTH'(MEM_WORDS));
  endfunction

  function automatic logic [IDX_W-1:0] widx(input logic [ADDR_WIDTH-1:0] a);
    return a[LG +: IDX_W];
  endfunction

  // WRAP keeps the upper address bits and wraps the low bits inside (len+1)<<size bytes.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [7:0] len,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step, nxt, wmask;
    step  = ADDR_WIDTH'(1) << size;
    nxt   = (a & ~(step - ADDR_WIDTH'(1))) + step;
    wmask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      2'b00:   return a;
      2'b10:   return (a & ~wmask) | (nxt & wmask);
      default: return nxt;
    endcase
  endfunction

  r_state_t              r_state, r_state_n;
  logic [ADDR_WIDTH-1:0] r_addr, r_ld_addr;
  logic [7:0]            r_len, r_beat, r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_bad, r_ld_bad, r_load;

  assign s_axi_rvalid = (r_state == R_BURST);
  assign s_axi_rlast  = s_axi_rvalid && (r_beat == r_len);

  // r_load marks the edges where rdata is refilled: entry into R_BURST and each non-final beat.
  always_comb begin
    r_state_n = r_state;
    r_load    = 1'b0;
    r_ld_addr = r_addr;
    r_ld_bad  = r_bad;
    case (r_state)
      R_IDLE: begin
        r_ld_addr = s_axi_araddr;
        r_ld_bad  = bad_req(s_axi_arsize, s_axi_arburst);
        if (s_axi_arvalid && s_axi_arready) begin
          if (READ_LATENCY == 0) begin
            r_state_n = R_BURST;
            r_load    = 1'b1;
          end else begin
            r_state_n = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_cnt == 8'(READ_LATENCY - 1)) begin
          r_state_n = R_BURST;
          r_load    = 1'b1;
        end
      end
      R_BURST: begin
        if (s_axi_rready) begin
          if (r_beat == r_len) begin
            r_state_n = R_IDLE;
          end else begin
            r_load    = 1'b1;
            r_ld_addr = next_addr(r_addr, r_len, r_size, r_burst);
          end
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
    end else begin
      r_state       <= r_state_n;
      s_axi_arready <= (r_state_n == R_IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_len       <= '0;
      r_size      <= '0;
      r_burst     <= '0;
      r_bad       <= 1'b0;
      r_beat      <= '0;
      r_cnt       <= '0;
      s_axi_rid   <= '0;
      s_axi_rdata <= '0;
      s_axi_rresp <= '0;
    end else begin
      if (r_state == R_IDLE && s_axi_arvalid && s_axi_arready) begin
        r_addr    <= s_axi_araddr;
        r_len     <= s_axi_arlen;
        r_size    <= s_axi_arsize;
        r_burst   <= s_axi_arburst;
        r_bad     <= bad_req(s_axi_arsize, s_axi_arburst);
        r_beat    <= '0;
        r_cnt     <= '0;
        s_axi_rid <= s_axi_arid;
      end
      if (r_state == R_WAIT) r_cnt <= r_cnt + 8'd1;
      if (r_state == R_BURST && s_axi_rready && r_beat != r_len) begin
        r_beat <= r_beat + 8'd1;
        r_addr <= r_ld_addr;
      end
      // Reads sample mem before this edge's write lands, so same-word collisions return old data.
      if (r_load) begin
        if (r_ld_bad) begin
          s_axi_rdata <= '0;
          s_axi_rresp <= 2'b10;
        end else if (oor(r_ld_addr)) begin
          s_axi_rdata <= '0;
          s_axi_rresp <= 2'b11;
        end else begin
          s_axi_rdata <= mem[widx(r_ld_addr)];
          s_axi_rresp <= 2'b00;
        end
      end
    end
  end

  w_state_t              w_state, w_state_n;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_beat, w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_bad, w_slv, w_dec;

  assign s_axi_wready = (w_state == W_DATA);
  assign s_axi_bvalid = (w_state == W_RESP);
  assign s_axi_bresp  = !s_axi_bvalid ? 2'b00 : w_slv ? 2'b10 : w_dec ? 2'b11 : 2'b00;

  always_comb begin
    w_state_n = w_state;
    case (w_state)
      W_IDLE: if (s_axi_awvalid && s_axi_awready) w_state_n = W_DATA;
      W_DATA: begin
        if (s_axi_wvalid && w_beat == w_len)
          w_state_n = (WRITE_LATENCY == 0) ? W_RESP : W_WAIT;
      end
      W_WAIT: if (w_cnt == 8'(WRITE_LATENCY - 1)) w_state_n = W_RESP;
      W_RESP: if (s_axi_bready) w_state_n = W_IDLE;
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
    end else begin
      w_state       <= w_state_n;
      s_axi_awready <= (w_state_n == W_IDLE);
    end
  end

  // The beat count follows awlen; a misplaced wlast only poisons the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_addr    <= '0;
      w_len     <= '0;
      w_size    <= '0;
      w_burst   <= '0;
      w_beat    <= '0;
      w_cnt     <= '0;
      w_bad     <= 1'b0;
      w_slv     <= 1'b0;
      w_dec     <= 1'b0;
      s_axi_bid <= '0;
    end else begin
      if (w_state == W_IDLE && s_axi_awvalid && s_axi_awready) begin
        w_addr    <= s_axi_awaddr;
        w_len     <= s_axi_awlen;
        w_size    <= s_axi_awsize;
        w_burst   <= s_axi_awburst;
        w_beat    <= '0;
        w_cnt     <= '0;
        w_bad     <= bad_req(s_axi_awsize, s_axi_awburst);
        w_slv     <= bad_req(s_axi_awsize, s_axi_awburst);
        w_dec     <= 1'b0;
        s_axi_bid <= s_axi_awid;
      end
      if (w_state == W_DATA && s_axi_wvalid) begin
        w_beat <= w_beat + 8'd1;
        w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
        if (s_axi_wlast != (w_beat == w_len)) w_slv <= 1'b1;
        if (!w_bad && oor(w_addr)) w_dec <= 1'b1;
      end
      if (w_state == W_WAIT) w_cnt <= w_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_state == W_DATA && s_axi_wvalid && !w_bad && !oor(w_addr)) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (s_axi_wstrb[i]) mem[widx(w_addr)][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi4_sim_ram.sv
// Randomised bench for axi4_sim_ram against a byte-array memory model with AXI beat-address arithmetic.
module tb_axi4_sim_ram;
  localparam int DW = 128;
  localparam int AW = 32;
  localparam int IW = 4;
  localparam int MW = 256;
  localparam int RL = 2;
  localparam int WL = 1;
  localparam int SB = DW / 8;

  logic          clk, rst;
  logic [IW-1:0] s_axi_awid, s_axi_bid, s_axi_arid, s_axi_rid;
  logic [AW-1:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]    s_axi_awlen, s_axi_arlen;
  logic [2:0]    s_axi_awsize, s_axi_arsize;
  logic [1:0]    s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic          s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic          s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic          s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [DW-1:0] s_axi_wdata, s_axi_rdata;
  logic [SB-1:0] s_axi_wstrb;

  axi4_sim_ram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_WORDS(MW),
    .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]    ref_mem [MW*SB];
  logic [DW-1:0] wdat_q [16];
  logic [SB-1:0] wstb_q [16];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                            input int size, input int burst, input int i);
    logic [31:0] step, aligned, wb, bound;
    step    = 32'd1 << size;
    aligned = (start / step) * step;
    if (i == 0 || burst == 0) return start;
    if (burst == 1) return aligned + 32'(i) * step;
    wb    = 32'(len + 1) * step;
    bound = (aligned / wb) * wb;
    return bound + ((aligned + 32'(i) * step) % wb);
  endfunction

  function automatic bit in_range(input logic [31:0] a);
`ifdef AXI4_SIM_RAM_DECERR_EN
    return (a / SB) < 32'(MW);
`else
    return (a / SB) == (a / SB);
`endif
  endfunction

  function automatic int ref_idx(input logic [31:0] a);
    return int'((a / SB) % 32'(MW));
  endfunction

  function automatic logic [DW-1:0] ref_word(input logic [31:0] a);
    logic [DW-1:0] w;
    for (int j = 0; j < SB; j++) w[8*j +: 8] = ref_mem[ref_idx(a)*SB + j];
    return w;
  endfunction

  task automatic send_ar(input int id, input logic [31:0] addr, input int len, input int size, input int burst);
    int n;
    s_axi_arid = IW'(id); s_axi_araddr = addr; s_axi_arlen = 8'(len);
    s_axi_arsize = 3'(size); s_axi_arburst = 2'(burst); s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 100) begin tick(); n++; end
    check("ar_ready", DW'(s_axi_arready), DW'(1));
    tick();
    s_axi_arvalid = 1'b0;
  endtask

  task automatic do_write(input int id, input logic [31:0] addr, input int len, input int size,
                          input int burst, input int wlast_at);
    int n;
    bit bad, slv, dec;
    logic [31:0] a;
    bad = (size > 4) || (burst == 3);
    slv = bad;
    dec = 1'b0;
    s_axi_awid = IW'(id); s_axi_awaddr = addr; s_axi_awlen = 8'(len);
    s_axi_awsize = 3'(size); s_axi_awburst = 2'(burst); s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 100) begin tick(); n++; end
    check("aw_ready", DW'(s_axi_awready), DW'(1));
    tick();
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      s_axi_wdata = wdat_q[i]; s_axi_wstrb = wstb_q[i];
      s_axi_wlast = (i == wlast_at); s_axi_wvalid = 1'b1;
      if ((i == wlast_at) != (i == len)) slv = 1'b1;
      a = beat_addr(addr, len, size, burst, i);
      if (!bad) begin
        if (!in_range(a)) dec = 1'b1;
        else for (int j = 0; j < SB; j++)
          if (wstb_q[i][j]) ref_mem[ref_idx(a)*SB + j] = wdat_q[i][8*j +: 8];
      end
      n = 0;
      while (!s_axi_wready && n < 100) begin tick(); n++; end
      check("w_ready", DW'(s_axi_wready), DW'(1));
      tick();
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    n = 1;
    while (!s_axi_bvalid && n < 300) begin tick(); n++; end
    check("b_latency", DW'(n), DW'(WL + 1));
    repeat ($urandom_range(0, 2)) tick();
    check("b_valid", DW'(s_axi_bvalid), DW'(1));
    check("b_id", DW'(s_axi_bid), DW'(id));
    check("b_resp", DW'(s_axi_bresp), DW'(slv ? 2 : dec ? 3 : 0));
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check("b_done", DW'(s_axi_bvalid), DW'(0));
  endtask

  // mode 0: rready held high, 1: toggles every cycle, 2: random
  task automatic do_read(input int id, input logic [31:0] addr, input int len, input int size,
                         input int burst, input int mode);
    int beat, cyc, lat;
    bit seen, bad;
    logic [31:0] a;
    logic [DW-1:0] exp_d;
    logic [1:0] exp_r;
    bad = (size > 4) || (burst == 3);
    send_ar(id, addr, len, size, burst);
    beat = 0; cyc = 0; lat = 1; seen = 1'b0;
    while (beat <= len && cyc < 2000) begin
      case (mode)
        0:       s_axi_rready = 1'b1;
        1:       s_axi_rready = (cyc % 2 == 0);
        default: s_axi_rready = 1'($urandom_range(0, 1));
      endcase
      if (s_axi_rvalid) begin
        if (!seen) begin
          seen = 1'b1;
          check("r_latency", DW'(lat), DW'(RL + 1));
        end
        a = beat_addr(addr, len, size, burst, beat);
        if (bad) begin exp_d = '0; exp_r = 2'b10; end
        else if (!in_range(a)) begin exp_d = '0; exp_r = 2'b11; end
        else begin exp_d = ref_word(a); exp_r = 2'b00; end
        check("r_data", s_axi_rdata, exp_d);
        check("r_resp", DW'(s_axi_rresp), DW'(exp_r));
        check("r_last", DW'(s_axi_rlast), DW'(beat == len));
        check("r_id", DW'(s_axi_rid), DW'(id));
        if (s_axi_rready) beat++;
      end else if (!seen) begin
        lat++;
      end
      tick();
      cyc++;
    end
    s_axi_rready = 1'b0;
    check("r_beats", DW'(beat), DW'(len + 1));
    check("r_done", DW'(s_axi_rvalid), DW'(0));
  endtask

  task automatic rand_wdata();
    for (int i = 0; i < 16; i++) begin
      wdat_q[i] = {$urandom, $urandom, $urandom, $urandom};
      wstb_q[i] = SB'($urandom);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
    s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    repeat (3) tick();
    check("rst_arready", DW'(s_axi_arready), DW'(0));
    check("rst_awready", DW'(s_axi_awready), DW'(0));
    check("rst_rvalid", DW'(s_axi_rvalid), DW'(0));
    check("rst_bvalid", DW'(s_axi_bvalid), DW'(0));
    check("rst_rlast", DW'(s_axi_rlast), DW'(0));
    check("rst_rdata", s_axi_rdata, '0);
    rst = 1'b0;
    check("pre_arready", DW'(s_axi_arready), DW'(0));
    tick();
    check("post_arready", DW'(s_axi_arready), DW'(1));
    check("post_awready", DW'(s_axi_awready), DW'(1));

    for (int k = 0; k < MW / 16; k++) begin
      rand_wdata();
      for (int i = 0; i < 16; i++) wstb_q[i] = '1;
      do_write(k % 16, 32'(k * 256), 15, 4, 1, 15);
    end

    for (int i = 0; i < 4; i++) begin wdat_q[i] = DW'(32'hA + i); wstb_q[i] = '1; end
    do_write(1, 32'h100, 3, 4, 1, 3);
    do_read(2, 32'h100, 3, 4, 1, 0);
    do_read(3, 32'h130, 3, 4, 2, 0);

    for (int i = 0; i < 4; i++) begin
      n = (32'h201 + i) % SB;
      wdat_q[i] = {$urandom, $urandom, $urandom, $urandom};
      wdat_q[i][8*n +: 8] = 8'(8'h50 + i);
      wstb_q[i] = SB'(1) << n;
    end
    do_write(4, 32'h201, 3, 0, 1, 3);
    do_read(5, 32'h200, 0, 4, 1, 0);

    do_read(6, 32'h400, 7, 4, 1, 1);

    rand_wdata();
    do_write(7, 32'h500, 3, 4, 1, 1);
    do_read(8, 32'h500, 3, 4, 1, 0);

    rand_wdata();
    do_write(9, 32'h600, 1, 5, 1, 1);
    do_read(10, 32'h600, 1, 4, 3, 2);
    do_read(11, 32'h600, 2, 7, 1, 0);

    do_read(12, 32'(MW * SB), 0, 4, 1, 0);
    rand_wdata();
    do_write(13, 32'(MW * SB + 32'h20), 0, 4, 1, 0);
    do_read(14, 32'h20, 0, 4, 1, 0);

    rand_wdata();
    fork
      do_write(13, 32'h700, 7, 4, 1, 7);
      do_read(14, 32'h900, 7, 4, 1, 2);
    join

    for (int t = 0; t < 40; t++) begin
      int burst, size, len, id;
      logic [31:0] addr;
      burst = $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0) burst = 3;
      size = $urandom_range(0, 4);
      if ($urandom_range(0, 9) == 0) size = $urandom_range(5, 7);
      if (burst == 2) len = (2 << $urandom_range(0, 3)) - 1;
      else len = $urandom_range(0, 15);
      addr = 32'($urandom_range(0, MW * SB * 2 - 1));
      addr = addr & ~((32'd1 << size) - 32'd1);
      id = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        rand_wdata();
        do_write(id, addr, len, size, burst, len);
      end else begin
        do_read(id, addr, len, size, burst, 2);
      end
    end

    send_ar(3, 32'h800, 7, 4, 1);
    s_axi_rready = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 50) begin tick(); n++; end
    check("mid_rvalid", DW'(s_axi_rvalid), DW'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_rvalid", DW'(s_axi_rvalid), DW'(0));
    check("mid_rst_rdata", s_axi_rdata, '0);
    check("mid_rst_arready", DW'(s_axi_arready), DW'(0));
    tick();
    rst = 1'b0;
    tick();
    check("mid_arready", DW'(s_axi_arready), DW'(1));
    do_read(4, 32'h800, 7, 4, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
